// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: instruction queue + dispatch scheduler.
//
// Buffers fetched {inst, pc} pairs in a 2^DEPTH_LOG-entry circular FIFO.
// The head entry is decoded combinationally. It is routed to the load/store
// buffer (LW/SW) or to the reservation station (everything else) once the ROB
// has room. Unsupported opcodes are dropped with a one-cycle illegal_out
// pulse. A flush empties the queue.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable), flush_in
//   if_valid / if_inst / if_pc / if_ready    : fetch side
//   rob_ready, rs_ready, lsb_ready           : downstream free-slot flags
//   rs_valid, lsb_valid                      : dispatch strobes (transfer when high)
//   dis_name/rd/rs1/rs2/imm/pc               : decoded head entry
//   illegal_out                              : registered drop pulse
//   stall_cnt                                : dispatch stall counter
//
// Build option: define DISPATCH_STALL_CNT_EN to build the saturating stall
// counter. When it is undefined, stall_cnt is tied to zero.
//
// Operation codes (dis_name): 0 none, 1 ADD, 2 SUB, 3 LW, 4 SW, 5 BEQ,
// 6 LUI, 7 AUIPC, 8 JAL, 9 JALR.

module dispatch_decode (
  input  logic [31:0] inst,
  output logic        legal,
  output logic        is_mem,
  output logic [5:0]  name,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm
);
  localparam logic [5:0] ADD = 6'd1, SUB = 6'd2, LW = 6'd3, SW = 6'd4,
                         BEQ = 6'd5, LUI = 6'd6, AUIPC = 6'd7, JAL = 6'd8,
                         JALR = 6'd9;

  localparam logic [6:0] OP_R     = 7'b0110011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BR   = 7'b1100011,
                         OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL   = 7'b1101111, OP_JALR = 7'b1100111;

  logic [31:0] imm_i;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};

  // Fields a format does not carry are left at their zero defaults.
  always_comb begin
    legal  = 1'b1;
    is_mem = 1'b0;
    name   = 6'd0;
    rd     = 5'd0;
    rs1    = 5'd0;
    rs2    = 5'd0;
    imm    = 32'd0;
    case (inst[6:0])
      OP_R: begin
        name = inst[30] ? SUB : ADD;
        rd   = inst[11:7];
        rs1  = inst[19:15];
        rs2  = inst[24:20];
      end
      OP_LOAD: begin
        name   = LW;
        is_mem = 1'b1;
        rd     = inst[11:7];
        rs1    = inst[19:15];
        imm    = imm_i;
      end
      OP_STORE: begin
        name   = SW;
        is_mem = 1'b1;
        rs1    = inst[19:15];
        rs2    = inst[24:20];
        imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BR: begin
        name = BEQ;
        rs1  = inst[19:15];
        rs2  = inst[24:20];
        imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI: begin
        name = LUI;
        rd   = inst[11:7];
        imm  = {inst[31:12], 12'd0};
      end
      OP_AUIPC: begin
        name = AUIPC;
        rd   = inst[11:7];
        imm  = {inst[31:12], 12'd0};
      end
      OP_JAL: begin
        name = JAL;
        rd   = inst[11:7];
        imm  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        name = JALR;
        rd   = inst[11:7];
        rs1  = inst[19:15];
        imm  = imm_i;
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

module dispatch_ctrl #(
  parameter int DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        rob_ready,
  input  logic        rs_ready,
  input  logic        lsb_ready,
  output logic        rs_valid,
  output logic        lsb_valid,
  output logic [5:0]  dis_name,
  output logic [4:0]  dis_rd,
  output logic [4:0]  dis_rs1,
  output logic [4:0]  dis_rs2,
  output logic [31:0] dis_imm,
  output logic [31:0] dis_pc,
  output logic        illegal_out,
  output logic [31:0] stall_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  entry_t                 mem_d [DEPTH];
  logic [DEPTH_LOG-1:0]   head_q, head_d;
  logic [DEPTH_LOG-1:0]   tail_q, tail_d;
  logic [DEPTH_LOG:0]     count_q, count_d;
  logic                   illegal_q, illegal_d;

  entry_t      head_ent;
  logic        not_empty, full, active, go, drop, enq, pop, show;
  logic        dec_legal, dec_is_mem;
  logic [5:0]  dec_name;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;

  assign head_ent  = mem_q[head_q];
  assign not_empty = count_q != '0;
  assign full      = count_q == FULL_CNT;

  dispatch_decode u_dec (
    .inst   (head_ent.inst),
    .legal  (dec_legal),
    .is_mem (dec_is_mem),
    .name   (dec_name),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .imm    (dec_imm)
  );

  // Reset outranks flush, which outranks rdy_in; all three fold into one gate.
  assign active    = !rst_in && rdy_in && !flush_in;
  // if_ready looks only at registered occupancy, never at downstream readies.
  assign if_ready  = active && !full;
  assign go        = active && not_empty && rob_ready;
  assign lsb_valid = go && dec_legal &&  dec_is_mem && lsb_ready;
  assign rs_valid  = go && dec_legal && !dec_is_mem && rs_ready;
  // An illegal head leaves without needing ROB or target space.
  assign drop      = active && not_empty && !dec_legal;
  assign enq       = if_valid && if_ready;
  assign pop       = rs_valid || lsb_valid || drop;

  assign show     = !rst_in && not_empty;
  assign dis_name = show ? dec_name     : 6'd0;
  assign dis_rd   = show ? dec_rd       : 5'd0;
  assign dis_rs1  = show ? dec_rs1      : 5'd0;
  assign dis_rs2  = show ? dec_rs2      : 5'd0;
  assign dis_imm  = show ? dec_imm      : 32'd0;
  assign dis_pc   = show ? head_ent.pc  : 32'd0;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[tail_q] = '{inst: if_inst, pc: if_pc};
        tail_d        = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      case ({enq, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // drop already implies rdy_in, so the pulse clears itself even while frozen.
  assign illegal_d = drop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign illegal_out = illegal_q;

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_inc;

  // A legal head that sits still for any reason (ROB or target full).
  assign stall_inc = rdy_in && !flush_in && not_empty && dec_legal &&
                     !(rs_valid || lsb_valid);

  always_comb begin
    stall_d = stall_q;
    if (stall_inc && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, if_valid;
  logic [31:0] if_inst, if_pc;
  logic        if_ready, rob_ready, rs_ready, lsb_ready, rs_valid, lsb_valid;
  logic [5:0]  dis_name;
  logic [4:0]  dis_rd, dis_rs1, dis_rs2;
  logic [31:0] dis_imm, dis_pc, stall_cnt;
  logic        illegal_out;

  always #5 clk_in = ~clk_in;

  dispatch_ctrl #(.DEPTH_LOG(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
    .rob_ready(rob_ready), .rs_ready(rs_ready), .lsb_ready(lsb_ready),
    .rs_valid(rs_valid), .lsb_valid(lsb_valid), .dis_name(dis_name),
    .dis_rd(dis_rd), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2), .dis_imm(dis_imm),
    .dis_pc(dis_pc), .illegal_out(illegal_out), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        ill;
    logic        lsb;
    logic [5:0]  name;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc, inst;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, n_ill = 0, n_disp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Builds an instruction word from fields and, separately, the decode the
  // scoreboard should see (fields outside the format forced to 0).
  function automatic exp_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    logic [11:0] i12;
    logic [12:0] b;
    logic [20:0] j;
    i12 = imm[11:0];
    b   = {imm[12:1], 1'b0};
    j   = {imm[20:1], 1'b0};
    e.ill = 1'b0; e.lsb = 1'b0; e.pc = pc; e.name = 6'd0;
    e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = 32'd0; e.inst = 32'd0;
    case (kind)
      0, 1: begin
        e.name = (kind == 0) ? 6'd1 : 6'd2;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.inst = {(kind == 1) ? 7'b0100000 : 7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      end
      2: begin
        e.name = 6'd3; e.lsb = 1'b1; e.rd = rd; e.rs1 = rs1;
        e.imm = {{20{i12[11]}}, i12};
        e.inst = {i12, rs1, 3'b010, rd, 7'b0000011};
      end
      3: begin
        e.name = 6'd4; e.lsb = 1'b1; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = {{20{i12[11]}}, i12};
        e.inst = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'b0100011};
      end
      4: begin
        e.name = 6'd5; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = {{19{b[12]}}, b};
        e.inst = {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'b1100011};
      end
      5, 6: begin
        e.name = (kind == 5) ? 6'd6 : 6'd7; e.rd = rd;
        e.imm = {imm[31:12], 12'd0};
        e.inst = {imm[31:12], rd, (kind == 5) ? 7'b0110111 : 7'b0010111};
      end
      7: begin
        e.name = 6'd8; e.rd = rd;
        e.imm = {{11{j[20]}}, j};
        e.inst = {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
      end
      default: begin
        e.name = 6'd9; e.rd = rd; e.rs1 = rs1;
        e.imm = {{20{i12[11]}}, i12};
        e.inst = {i12, rs1, 3'b000, rd, 7'b1100111};
      end
    endcase
    return e;
  endfunction

  function automatic exp_t mk_ill(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e = mk(0, 5'd0, 5'd0, 5'd0, 32'd0, pc);
    e.ill = 1'b1; e.inst = inst;
    return e;
  endfunction

  function automatic exp_t rnd(input int k, input logic [31:0] pc);
    return mk(k % 9, 5'($urandom_range(31)), 5'($urandom_range(31)),
              5'($urandom_range(31)), $urandom, pc);
  endfunction

  // Scoreboard consumer: illegal pulses and dispatches pop in queue order.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (!rst_in) begin
      if (illegal_out) begin
        n_ill++;
        if (sb.size() == 0) chk("ill_sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ill_expected", e.ill, 1);
        end
      end
      if (rs_valid || lsb_valid) begin
        n_disp++;
        if (sb.size() == 0) chk("disp_sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk("disp_not_ill", e.ill, 0);
          chk("route", {rs_valid, lsb_valid}, {!e.lsb, e.lsb});
          chk("fields", {dis_name, dis_rd, dis_rs1, dis_rs2}, {e.name, e.rd, e.rs1, e.rs2});
          chk("imm", dis_imm, e.imm);
          chk("pc", dis_pc, e.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic enq(input exp_t e);
    int n;
    n = 0;
    if_valid = 1'b1; if_inst = e.inst; if_pc = e.pc;
    while (!if_ready && n < 300) begin
      tick();
      n++;
    end
    if (!if_ready) chk("enq_timeout", 0, 1);
    else sb.push_back(e);
    tick();
    if_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, i0;
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; if_valid = 1'b0;
    if_inst = 32'd0; if_pc = 32'd0;
    rob_ready = 1'b1; rs_ready = 1'b1; lsb_ready = 1'b1;
    tick(); tick();
    chk("rst_if_ready", if_ready, 0);
    chk("rst_valids", {rs_valid, lsb_valid}, 0);
    chk("rst_dis", {dis_name, dis_pc, dis_imm}, 0);
    chk("rst_illegal", illegal_out, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_in = 1'b0; #1;
    chk("post_rst_if_ready", if_ready, 1);

    // Basic RS dispatch: add x3,x1,x2 at pc 0.
    enq(mk(0, 5'd3, 5'd1, 5'd2, 32'd0, 32'd0));
    chk("t1_rs_valid", rs_valid, 1);
    chk("t1_name", dis_name, 6'd1);
    tick();
    chk("t1_empty_valids", {rs_valid, lsb_valid}, 0);

    // LSB backpressure: lw x5,8(x1) then sw x5,4(x2).
    lsb_ready = 1'b0;
    enq(mk(2, 5'd5, 5'd1, 5'd0, 32'd8, 32'd4));
    enq(mk(3, 5'd0, 5'd2, 5'd5, 32'd4, 32'd8));
    tick(); tick();
    chk("t2_no_dispatch", {rs_valid, lsb_valid}, 0);
`ifdef DISPATCH_STALL_CNT_EN
    chk("t2_stall", stall_cnt, 3);
`else
    chk("t2_stall", stall_cnt, 0);
`endif
    lsb_ready = 1'b1; #1;
    chk("t2_lw_valid", lsb_valid, 1);
    chk("t2_lw_imm", dis_imm, 8);
    tick();
    chk("t2_sw_valid", lsb_valid, 1);
    chk("t2_sw_name", dis_name, 6'd4);
    tick();
    chk("t2_done", lsb_valid, 0);

    // Fill to 8 with the ROB blocked, then stream 20 more across the wrap.
    d0 = n_disp;
    rob_ready = 1'b0;
    for (int k = 0; k < 8; k++) enq(rnd(k, 32'h100 + 32'(4 * k)));
    chk("t3_full_if_ready", if_ready, 0);
    if_valid = 1'b1; if_inst = 32'h002081B3; if_pc = 32'hDEAD;
    tick();
    chk("t3_full_hold1", if_ready, 0);
    tick();
    chk("t3_full_hold2", if_ready, 0);
    if_valid = 1'b0;
    rob_ready = 1'b1;
    for (int k = 8; k < 28; k++) enq(rnd(k, 32'h100 + 32'(4 * k)));
    drain();
    chk("t3_disp_count", n_disp - d0, 28);

    // Illegal drop followed by an ADD.
    i0 = n_ill;
    enq(mk_ill(32'h00000013, 32'h200));
    enq(mk(0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h204));
    chk("t4_illegal_pulse", illegal_out, 1);
    chk("t4_add_valid", rs_valid, 1);
    chk("t4_add_pc", dis_pc, 32'h204);
    tick();
    chk("t4_pulse_end", illegal_out, 0);
    chk("t4_pulse_count", n_ill - i0, 1);

    // Flush with a simultaneous fetch and ready targets.
    rob_ready = 1'b0;
    for (int k = 0; k < 5; k++) enq(rnd(k, 32'h400 + 32'(4 * k)));
    flush_in = 1'b1; if_valid = 1'b1; if_inst = 32'h002081B3; if_pc = 32'h500;
    rs_ready = 1'b1; rob_ready = 1'b1; #1;
    chk("t5_flush_valids", {rs_valid, lsb_valid}, 0);
    chk("t5_flush_if_ready", if_ready, 0);
    tick();
    sb.delete();
    flush_in = 1'b0; if_valid = 1'b0; #1;
    chk("t5_after_valids", {rs_valid, lsb_valid}, 0);
    chk("t5_after_if_ready", if_ready, 1);
    tick(); tick();
    chk("t5_not_stored", {rs_valid, lsb_valid}, 0);

    // rdy_in freeze, then reset mid-operation.
    rob_ready = 1'b0;
    for (int k = 0; k < 3; k++) enq(mk(0, 5'(k + 1), 5'd2, 5'd3, 32'd0, 32'h300 + 32'(4 * k)));
    rdy_in = 1'b0; rob_ready = 1'b1; if_valid = 1'b1; if_inst = 32'h00512223; #1;
    chk("t6_freeze_valids", {rs_valid, lsb_valid}, 0);
    chk("t6_freeze_if_ready", if_ready, 0);
    tick();
    chk("t6_freeze2_valids", {rs_valid, lsb_valid}, 0);
    tick();
    rdy_in = 1'b1; if_valid = 1'b0; #1;
    chk("t6_thaw_valid", rs_valid, 1);
    chk("t6_thaw_pc", dis_pc, 32'h300);
    tick();
    rst_in = 1'b1; #1;
    chk("t6_rst_if_ready", if_ready, 0);
    chk("t6_rst_valids", {rs_valid, lsb_valid}, 0);
    chk("t6_rst_dis_pc", dis_pc, 0);
    tick();
    sb.delete();
    rst_in = 1'b0; #1;
    chk("t6_post_if_ready", if_ready, 1);
    chk("t6_post_valids", {rs_valid, lsb_valid}, 0);
    chk("t6_post_stall", stall_cnt, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Instruction queue and dispatch scheduler between instruction fetch and the issue structures. Buffers fetched instructions with their PC in a circular FIFO and decodes the head entry with the shared `Decode` block. Routes each decoded instruction to the reservation station (RS) or the load/store buffer (LSB), gated on ROB space. Drops unsupported opcodes and empties the queue on a pipeline flush.

## Interface
- `DEPTH_LOG`, default 3: queue holds 2^DEPTH_LOG entries (default 8).
- `clk_in` in 1: clock; all state updates on the rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global enable; when low all state holds.
- `flush_in` in 1: misprediction flush; clears the queue.
- `if_valid` in 1: fetch presents an instruction.
- `if_inst` in 32: instruction word.
- `if_pc` in 32: PC of `if_inst`.
- `if_ready` out 1: queue accepts an instruction this cycle.
- `rob_ready` in 1: ROB has at least one free slot.
- `rs_ready` in 1: RS has at least one free slot.
- `lsb_ready` in 1: LSB has at least one free slot.
- `rs_valid` out 1: head is dispatching to the RS.
- `lsb_valid` out 1: head is dispatching to the LSB.
- `dis_name` out 6: operation code from `const.v` (`ADD`, `SUB`, `LW`, `SW`, `BEQ`, `LUI`, `AUIPC`, `JAL`, `JALR`).
- `dis_rd`, `dis_rs1`, `dis_rs2` out 5 each: register fields.
- `dis_imm` out 32: sign-extended immediate.
- `dis_pc` out 32: PC of the head entry.
- `illegal_out` out 1: one-cycle pulse when an unsupported instruction is dropped.
- `stall_cnt` out 32: dispatch stall counter (see Configuration).

## Operation
- Storage: per entry, {inst[31:0], pc[31:0]}. State is `head`, `tail` (DEPTH_LOG bits each, natural wrap) and `count` (DEPTH_LOG+1 bits).
- `if_ready` = !rst_in && rdy_in && !flush_in && count != 2^DEPTH_LOG.
- Enqueue when `if_valid && if_ready`: write at `tail`, then `tail`+1.
- The head instruction feeds a combinational `Decode` instance.
- Supported opcodes: 0110011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111. Any other opcode is illegal.
- `go` = count != 0 && rdy_in && !flush_in && rob_ready.
- Routing:
  - `lsb_valid` = go && legal && name ∈ {LW, SW} && lsb_ready.
  - `rs_valid` = go && legal && name ∉ {LW, SW} && rs_ready.
  - Valids are combinational and assert only when the target can accept, so a transfer occurs every cycle a valid is high.
- Pop the head (`head`+1) when `rs_valid || lsb_valid`.
- Illegal head: when count != 0 && rdy_in && !flush_in && !legal, pop without dispatch and assert `illegal_out` registered for one cycle. ROB and target readiness are ignored for this pop.
- Fields the decoder does not produce for a format drive 0: rd for SW/BEQ, rs2 for I/U/J formats, rs1 for U/J formats, imm for R-type.
- When count == 0, all `dis_*` outputs drive 0.
- At most one enqueue and one pop per cycle. Simultaneous enqueue and pop leaves `count` unchanged; this is legal when the queue is non-full. A full queue never enqueues.
- Flush: on an edge with `flush_in` high, head = tail = count = 0. Any same-cycle enqueue or pop is suppressed.
- Reset: head = tail = count = 0, `illegal_out` = 0, `stall_cnt` = 0. During reset `if_ready`, `rs_valid` and `lsb_valid` are 0 and all `dis_*` outputs are 0.
- `rst_in` takes priority over `flush_in`, which takes priority over `rdy_in` gating.

## Timing
- Enqueue-to-dispatch latency is 1 cycle minimum. An instruction written at edge N can dispatch in cycle N+1, transferring at edge N+1.
- Throughput is one instruction per cycle with no bubbles while target and ROB are ready.
- An illegal entry costs one cycle.
- All outputs except `illegal_out` and `stall_cnt` are combinational from registered state plus ready inputs. Ready inputs have no combinational path to `if_ready`.

## Configuration
- `DISPATCH_STALL_CNT_EN` defined: `stall_cnt` increments each cycle with rdy_in && !flush_in && count != 0 && legal head && !(rs_valid || lsb_valid). It saturates at 0xFFFFFFFF and is cleared only by reset.
- Not defined: `stall_cnt` is tied to 0 and no counter logic is built. The port exists in both builds.

## Test plan
- **Basic RS dispatch.** Reset, then enqueue 0x002081B3 (add x3,x1,x2) at pc 0x0 with all readies high. Next cycle: rs_valid=1, dis_name=`ADD`, rd=3, rs1=1, rs2=2, imm=0, pc=0. The following cycle count=0 and valids are low.
- **Routing under backpressure.** Enqueue 0x0080A283 (lw x5,8(x1)) then 0x00512223 (sw x5,4(x2)), with lsb_ready=0 for 3 cycles. Expect no dispatch and stall_cnt=3 when the macro is on. Then set lsb_ready=1: LW dispatches with imm=8, then SW with imm=4, rs2=5, rd=0, on consecutive cycles.
- **Full and wrap.** Hold rob_ready=0 and enqueue 8 instructions: if_ready drops after the 8th. Release rob_ready and stream 20 more. All 28 dispatch in order with correct PCs across pointer wrap, and if_ready never rises while count==8.
- **Illegal drop.** Enqueue 0x00000013 then 0x002081B3. Expect illegal_out pulses once, no valid for the first entry, and ADD dispatches the cycle after the drop.
- **Flush with simultaneous events.** Queue 5 entries, then assert flush_in together with if_valid=1 and rs_ready=1. Next cycle count=0 and valids are low. The instruction presented during the flush is not stored.
- **Reset mid-operation and rdy_in freeze.** With 3 entries queued, rdy_in=0 for 2 cycles: no transfers and state is unchanged. Then rst_in=1 for 1 cycle: count=0, if_ready=0 during reset and 1 after.
